ones_generator: RTL

ONES_GENERATOR -- requirements
Module: ones_generator

---
 rtl/ones_generator.sv | 90 +++++++++
 1 files changed

// File: rtl/ones_generator.sv
// Shifts in N ones (N = count_in saturated at 8) from the LSB end, then holds the word until start falls.
// Optional even-parity output is enabled with the ONES_GENERATOR_PARITY_EN macro.
module ones_generator (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] count_in,
   output logic [7:0] word_out,
   output logic       busy,
   output logic       done
`ifdef ONES_GENERATOR_PARITY_EN
   ,
   output logic       parity
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_q;
   logic [3:0] rem_q;
   logic [3:0] rem_d;
   logic [3:0] count_sat;
   logic [7:0] shreg_q;
   logic [7:0] shreg_d;
   logic       busy_q;
   logic       done_q;

   assign count_sat = (count_in > 4'd8) ? 4'd8 : count_in;
   // rem_d is only committed when rem_q != 0, so the counter never wraps.
   assign rem_d     = rem_q - 4'd1;
   assign shreg_d   = {shreg_q[6:0], 1'b1};

   // busy_q/done_q are loaded together with every state change, so they always
   // equal (state_q == FILL) and (state_q == DONE).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         rem_q   <= 4'd0;
         shreg_q <= 8'h00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= FILL;
                  busy_q  <= 1'b1;
               end else begin
                  rem_q   <= count_sat;
                  shreg_q <= 8'h00;
               end
            end
            FILL: begin
               if (rem_q != 4'd0) begin
                  shreg_q <= shreg_d;
                  rem_q   <= rem_d;
               end else begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               if (!start) begin
                  state_q <= IDLE;
                  done_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign word_out = shreg_q;
   assign busy     = busy_q;
   assign done     = done_q;

`ifdef ONES_GENERATOR_PARITY_EN
   assign parity = ^shreg_q;
`endif

endmodule
